// File: rtl/ppu_feed_sched_if.sv
// Requester and ppu byte handshakes of the ppu feed scheduler.
// master = the side that drives requests and acks bytes; slave = scheduler.
interface ppu_feed_sched_if;
  logic [7:0] rq0_data;
  logic       rq0_stb;
  logic       rq0_ack;
  logic [7:0] rq1_data;
  logic       rq1_stb;
  logic       rq1_ack;
  logic [7:0] data_o;
  logic       stb_o;
  logic       ack_o;

  modport master (
    output rq0_data, rq0_stb,
    input  rq0_ack,
    output rq1_data, rq1_stb,
    input  rq1_ack,
    input  data_o, stb_o,
    output ack_o
  );

  modport slave (
    input  rq0_data, rq0_stb,
    output rq0_ack,
    input  rq1_data, rq1_stb,
    output rq1_ack,
    output data_o, stb_o,
    input  ack_o
  );
endinterface

// File: rtl/ppu_feed_sched.sv
// Two-port round-robin byte feeder for the ppu, one line per sync pulse.
// Tracks completed lines, latched mode and sticky underrun.
module ppu_feed_sched #(
  parameter int LINE_BYTES = 32,
  parameter int BURST      = 8,
  parameter int LINE_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic [2:0]        mode_i,
  ppu_feed_sched_if.slave   bus,
  output logic [2:0]        mode_o,
  output logic [LINE_W-1:0] line_cnt,
  output logic              line_done,
  output logic              underrun
);

  localparam int BC_W = $clog2(LINE_BYTES) + 1;
  localparam int BU_W = $clog2(BURST) + 1;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    ARB,
    LOAD,
    SEND
  } state_t;

  state_t state, nxt;

  logic            sync_q;
  logic            sync_pend;
  logic [2:0]      mode_pend;
  logic            rr;
  logic            grant;
  logic [BC_W-1:0] byte_cnt;
  logic [BU_W-1:0] burst_cnt;

  logic       sync_edge;
  logic       last;
  logic       burst_end;
  logic       any_req;
  logic       pick;
  logic       g_stb;
  logic [7:0] g_data;

  logic consume;
  logic arb_go;
  logic take;
  logic drop;
  logic accept;

  assign sync_edge = sync & ~sync_q;
  assign last      = byte_cnt == BC_W'(LINE_BYTES - 1);
  assign burst_end = burst_cnt == BU_W'(BURST - 1);
  assign any_req   = bus.rq0_stb | bus.rq1_stb;
  assign pick      = rr ? bus.rq1_stb : ~bus.rq0_stb;
  assign g_stb     = grant ? bus.rq1_stb : bus.rq0_stb;
  assign g_data    = grant ? bus.rq1_data : bus.rq0_data;

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_SYNC;
    else     state <= nxt;
  end

  always_comb begin
    nxt     = state;
    consume = 1'b0;
    arb_go  = 1'b0;
    take    = 1'b0;
    drop    = 1'b0;
    accept  = 1'b0;
    unique case (state)
      WAIT_SYNC: begin
        if (sync_pend) begin
          consume = 1'b1;
          nxt     = ARB;
        end
      end
      ARB: begin
        // a pending sync restarts the line before granting
        consume = sync_pend;
        if (any_req) begin
          arb_go = 1'b1;
          nxt    = LOAD;
        end
      end
      LOAD: begin
        if (g_stb) begin
          take = 1'b1;
          nxt  = SEND;
        end else begin
          drop = 1'b1;
          nxt  = ARB;
        end
      end
      SEND: begin
        if (bus.ack_o) begin
          accept = 1'b1;
          if (last)
            nxt = WAIT_SYNC;
          else if (burst_end | sync_pend | sync_edge)
            nxt = ARB;
          else
            nxt = LOAD;
        end
      end
      default: nxt = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 1'b0;
      sync_pend   <= 1'b0;
      mode_pend   <= 3'd0;
      mode_o      <= 3'd0;
      rr          <= 1'b0;
      grant       <= 1'b0;
      byte_cnt    <= '0;
      burst_cnt   <= '0;
      bus.data_o  <= 8'h00;
      bus.stb_o   <= 1'b0;
      bus.rq0_ack <= 1'b0;
      bus.rq1_ack <= 1'b0;
      line_cnt    <= '0;
      line_done   <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      sync_q      <= sync;
      bus.rq0_ack <= 1'b0;
      bus.rq1_ack <= 1'b0;
      line_done   <= 1'b0;

      if (sync_edge) begin
        sync_pend <= 1'b1;
        mode_pend <= mode_i;
      end else if (consume) begin
        sync_pend <= 1'b0;
      end

      if (consume) begin
        mode_o   <= mode_pend;
        byte_cnt <= '0;
      end

      if (arb_go) begin
        grant     <= pick;
        burst_cnt <= '0;
      end

      if (drop) rr <= ~grant;

      if (take) begin
        bus.data_o  <= g_data;
        bus.stb_o   <= 1'b1;
        bus.rq0_ack <= ~grant;
        bus.rq1_ack <= grant;
      end

      if (accept) begin
        bus.stb_o <= 1'b0;
        byte_cnt  <= byte_cnt + BC_W'(1);
        burst_cnt <= burst_cnt + BU_W'(1);
        if (last) begin
          line_done <= 1'b1;
          line_cnt  <= line_cnt + LINE_W'(1);
          rr        <= ~grant;
        end else if (burst_end) begin
          rr <= ~grant;
        end
      end

      // a sync landing on the final ack closes the line cleanly
      if (sync_edge && state != WAIT_SYNC && !(accept && last))
        underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ppu_feed_sched.sv
// Randomized bench for ppu_feed_sched with a line/burst reference model.
// Requesters and ppu are modelled as queues driven from initial blocks.
module tb_ppu_feed_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync = 1'b0;
  logic [2:0] mode_i = 3'd0;
  logic [2:0] mode_o;
  logic [9:0] line_cnt;
  logic       line_done;
  logic       underrun;

  ppu_feed_sched_if bus();

  ppu_feed_sched #(
    .LINE_BYTES(32),
    .BURST(8),
    .LINE_W(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sync(sync),
    .mode_i(mode_i),
    .bus(bus.slave),
    .mode_o(mode_o),
    .line_cnt(line_cnt),
    .line_done(line_done),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  logic [7:0] src0[$];
  logic [7:0] src1[$];
  logic [7:0] obs[$];
  int         ports[$];
  int         i0 = 0;
  int         i1 = 0;
  logic       force_stb = 1'b0;
  int         ld_cnt = 0;
  int         rqack_cnt = 0;
  int         both_err = 0;
  int         stop_at = 1 << 30;
  logic       rand_ack = 1'b0;
  int         tests = 0;
  int         fails = 0;

  // requesters: present head byte, advance on ack
  initial begin
    bus.rq0_stb  = 1'b0;
    bus.rq1_stb  = 1'b0;
    bus.rq0_data = 8'h00;
    bus.rq1_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (bus.rq0_ack && bus.rq1_ack) both_err++;
      if (bus.rq0_ack) begin i0++; ports.push_back(0); rqack_cnt++; end
      if (bus.rq1_ack) begin i1++; ports.push_back(1); rqack_cnt++; end
      if (line_done) ld_cnt++;
      bus.rq0_stb  = force_stb || (i0 < src0.size());
      bus.rq0_data = (i0 < src0.size()) ? src0[i0] : 8'h00;
      bus.rq1_stb  = force_stb || (i1 < src1.size());
      bus.rq1_data = (i1 < src1.size()) ? src1[i1] : 8'h00;
    end
  end

  // ppu: ack a strobed byte after a delay, record it
  initial begin
    int wc = 0;
    int dly = 0;
    bus.ack_o = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        bus.ack_o = 1'b0;
        wc = 0;
      end else if (bus.ack_o) begin
        bus.ack_o = 1'b0;
      end else if (bus.stb_o && obs.size() < stop_at) begin
        if (wc >= dly) begin
          bus.ack_o = 1'b1;
          obs.push_back(bus.data_o);
          wc = 0;
          dly = rand_ack ? int'($urandom_range(0, 3)) : 0;
        end else begin
          wc++;
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_sync(input logic [2:0] m);
    mode_i = m;
    sync = 1'b1;
    tick();
    sync = 1'b0;
    mode_i = ~m;
  endtask

  function automatic int seq_bad(input int base, input logic [7:0] e[$]);
    int bad = 0;
    if (obs.size() != base + e.size()) bad++;
    for (int i = 0; i < e.size(); i++)
      if (base + i >= obs.size() || obs[base + i] !== e[i]) bad++;
    return bad;
  endfunction

  task automatic wait_lines(input int target, input int budget, output bit ok);
    int t = 0;
    while (ld_cnt < target && t < budget) begin tick(); t++; end
    ok = (ld_cnt >= target);
  endtask

  task automatic wait_held(input int n, input int budget, output bit ok);
    int t = 0;
    while (!(bus.stb_o && obs.size() == n) && t < budget) begin tick(); t++; end
    ok = bus.stb_o && obs.size() == n;
  endtask

  task automatic test_reset();
    int seen = 0;
    rst = 1'b1;
    repeat (3) tick();
    tests++;
    if ({bus.stb_o, bus.rq0_ack, bus.rq1_ack, line_done} !== 4'b0) begin
      fails++;
      $display("FAIL reset_hs: stb/ack0/ack1/done=%b required 0000",
               {bus.stb_o, bus.rq0_ack, bus.rq1_ack, line_done});
    end
    tests++;
    if (line_cnt !== 10'd0 || underrun !== 1'b0 || mode_o !== 3'd0) begin
      fails++;
      $display("FAIL reset_regs: line_cnt=%0d underrun=%b mode=%0d required 0",
               line_cnt, underrun, mode_o);
    end
    rst = 1'b0;
    force_stb = 1'b1;
    repeat (20) begin
      tick();
      if (bus.stb_o || bus.rq0_ack || bus.rq1_ack) seen++;
    end
    force_stb = 1'b0;
    tick();
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL no_sync_idle: %0d active cycles, required 0", seen);
    end
  endtask

  task automatic test_single_port();
    logic [7:0] e[$];
    int base, ld0, bad;
    bit ok;
    do_reset();
    rand_ack = 1'b0;
    base = obs.size();
    ld0 = ld_cnt;
    for (int i = 0; i < 32; i++) begin
      src0.push_back(8'(i));
      e.push_back(8'(i));
    end
    pulse_sync(3'd5);
    wait_lines(ld0 + 1, 600, ok);
    repeat (4) tick();
    tests++;
    if (!ok) begin fails++; $display("FAIL single_timeout: no line_done, required 1"); end
    bad = seq_bad(base, e);
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL single_seq: %0d bad of %0d bytes, required 0", bad, obs.size() - base);
    end
    tests++;
    if (mode_o !== 3'd5) begin fails++; $display("FAIL single_mode: %0d required 5", mode_o); end
    tests++;
    if (line_cnt !== 10'd1 || ld_cnt - ld0 !== 1) begin
      fails++;
      $display("FAIL single_lines: line_cnt=%0d pulses=%0d required 1/1", line_cnt, ld_cnt - ld0);
    end
    tests++;
    if (underrun !== 1'b0) begin fails++; $display("FAIL single_underrun: %b required 0", underrun); end
  endtask

  task automatic test_alternate();
    logic [7:0] a[$], b[$], e[$];
    int ep[$];
    int base, pbase, ld0, be0, bad, pref;
    bit ok;
    do_reset();
    rand_ack = 1'b1;
    base = obs.size();
    pbase = ports.size();
    ld0 = ld_cnt;
    be0 = both_err;
    for (int i = 0; i < 16; i++) begin
      a.push_back(8'($urandom));
      b.push_back(8'($urandom));
    end
    // both always ready: whole bursts alternate from port 0
    pref = 0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) begin
        e.push_back(pref == 0 ? a[(k / 2) * 8 + j] : b[(k / 2) * 8 + j]);
        ep.push_back(pref);
      end
      pref = 1 - pref;
    end
    foreach (a[i]) src0.push_back(a[i]);
    foreach (b[i]) src1.push_back(b[i]);
    pulse_sync(3'($urandom));
    wait_lines(ld0 + 1, 1000, ok);
    repeat (4) tick();
    rand_ack = 1'b0;
    bad = seq_bad(base, e);
    tests++;
    if (!ok || bad !== 0) begin
      fails++;
      $display("FAIL alt_seq: done=%b bad=%0d required done=1 bad=0", ok, bad);
    end
    bad = (ports.size() - pbase != 32) ? 1 : 0;
    for (int i = 0; i < 32 && pbase + i < ports.size(); i++)
      if (ports[pbase + i] !== ep[i]) bad++;
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL alt_ports: %0d grant order errors, required 0", bad);
    end
    tests++;
    if (line_cnt !== 10'd1) begin fails++; $display("FAIL alt_lines: %0d required 1", line_cnt); end
    tests++;
    if (both_err !== be0) begin
      fails++;
      $display("FAIL alt_both_ack: %0d cycles with two acks, required 0", both_err - be0);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] e[$];
    logic [2:0] m1, m2;
    int base, ld0, bad;
    bit ok;
    do_reset();
    rand_ack = 1'b0;
    base = obs.size();
    ld0 = ld_cnt;
    m1 = 3'($urandom);
    m2 = m1 ^ 3'($urandom_range(1, 7));
    // 11 bytes of the broken line plus a full 32-byte line
    for (int i = 0; i < 43; i++) e.push_back(8'($urandom));
    foreach (e[i]) src0.push_back(e[i]);
    stop_at = base + 10;
    pulse_sync(m1);
    wait_held(base + 10, 300, ok);
    tests++;
    if (!ok || mode_o !== m1) begin
      fails++;
      $display("FAIL ur_mode_hold: held=%b mode=%0d required held=1 mode=%0d", ok, mode_o, m1);
    end
    pulse_sync(m2);
    tick();
    tests++;
    if (underrun !== 1'b1 || line_cnt !== 10'd0) begin
      fails++;
      $display("FAIL ur_flag: underrun=%b line_cnt=%0d required 1/0", underrun, line_cnt);
    end
    stop_at = 1 << 30;
    wait_lines(ld0 + 1, 800, ok);
    repeat (4) tick();
    bad = seq_bad(base, e);
    tests++;
    if (!ok || bad !== 0) begin
      fails++;
      $display("FAIL ur_restart: done=%b bytes=%0d bad=%0d required 1/43/0",
               ok, obs.size() - base, bad);
    end
    tests++;
    if (line_cnt !== 10'd1 || mode_o !== m2 || underrun !== 1'b1) begin
      fails++;
      $display("FAIL ur_after: line_cnt=%0d mode=%0d underrun=%b required 1/%0d/1",
               line_cnt, mode_o, underrun, m2);
    end
  endtask

  task automatic test_ack_hold();
    logic [7:0] e[$];
    logic [7:0] d;
    int base, ld0, a, unstable, bad;
    bit ok;
    do_reset();
    rand_ack = 1'b1;
    base = obs.size();
    ld0 = ld_cnt;
    for (int i = 0; i < 32; i++) e.push_back(8'($urandom));
    foreach (e[i]) src1.push_back(e[i]);
    stop_at = base + 3;
    pulse_sync(3'($urandom));
    wait_held(base + 3, 300, ok);
    d = bus.data_o;
    tick();
    a = rqack_cnt;
    unstable = ok ? 0 : 1;
    repeat (5) begin
      if (bus.stb_o !== 1'b1 || bus.data_o !== d) unstable++;
      tick();
    end
    tests++;
    if (unstable !== 0) begin
      fails++;
      $display("FAIL hold_stable: %0d unstable cycles, required 0", unstable);
    end
    tests++;
    if (rqack_cnt !== a) begin
      fails++;
      $display("FAIL hold_no_ack: %0d rq acks, required 0", rqack_cnt - a);
    end
    stop_at = 1 << 30;
    wait_lines(ld0 + 1, 1000, ok);
    repeat (4) tick();
    rand_ack = 1'b0;
    bad = seq_bad(base, e);
    tests++;
    if (!ok || bad !== 0 || line_cnt !== 10'd1) begin
      fails++;
      $display("FAIL hold_resume: done=%b bad=%0d line_cnt=%0d required 1/0/1",
               ok, bad, line_cnt);
    end
  endtask

  task automatic test_sync_coincident();
    logic [7:0] e[$];
    logic [2:0] m1, m2;
    int base, ld0, bad;
    bit ok;
    do_reset();
    rand_ack = 1'b0;
    base = obs.size();
    ld0 = ld_cnt;
    m1 = 3'($urandom);
    m2 = m1 ^ 3'($urandom_range(1, 7));
    for (int i = 0; i < 64; i++) e.push_back(8'($urandom));
    foreach (e[i]) src0.push_back(e[i]);
    stop_at = base + 31;
    pulse_sync(m1);
    wait_held(base + 31, 400, ok);
    // release the last ack in the same cycle the sync rises
    mode_i = m2;
    sync = 1'b1;
    stop_at = 1 << 30;
    tick();
    sync = 1'b0;
    tests++;
    if (!ok || line_done !== 1'b1) begin
      fails++;
      $display("FAIL co_done: held=%b line_done=%b required 1/1", ok, line_done);
    end
    tick();
    tests++;
    if (underrun !== 1'b0 || line_cnt !== 10'd1) begin
      fails++;
      $display("FAIL co_clean: underrun=%b line_cnt=%0d required 0/1", underrun, line_cnt);
    end
    wait_lines(ld0 + 2, 800, ok);
    repeat (4) tick();
    bad = seq_bad(base, e);
    tests++;
    if (!ok || bad !== 0) begin
      fails++;
      $display("FAIL co_next_line: done=%b bytes=%0d bad=%0d required 1/64/0",
               ok, obs.size() - base, bad);
    end
    tests++;
    if (line_cnt !== 10'd2 || underrun !== 1'b0 || mode_o !== m2) begin
      fails++;
      $display("FAIL co_after: line_cnt=%0d underrun=%b mode=%0d required 2/0/%0d",
               line_cnt, underrun, mode_o, m2);
    end
  endtask

  task automatic test_reset_mid_send();
    int base, ld0;
    bit ok;
    do_reset();
    base = obs.size();
    ld0 = ld_cnt;
    for (int i = 0; i < 8; i++) src0.push_back(8'($urandom));
    stop_at = base + 2;
    pulse_sync(3'($urandom));
    wait_held(base + 2, 200, ok);
    rst = 1'b1;
    tick();
    tests++;
    if (!ok || bus.stb_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_send_stb: held=%b stb_o=%b required 1/0", ok, bus.stb_o);
    end
    rst = 1'b0;
    stop_at = 1 << 30;
    repeat (10) tick();
    tests++;
    if (ld_cnt !== ld0 || line_cnt !== 10'd0) begin
      fails++;
      $display("FAIL rst_send_line: pulses=%0d line_cnt=%0d required 0/0",
               ld_cnt - ld0, line_cnt);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_single_port();
    test_alternate();
    test_underrun();
    test_ack_hold();
    test_sync_coincident();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
